kwta_inhibition: RTL and testbench

//  Parametrised k-winner-take-all lateral inhibition for one excitatory column.

---
 rtl/kwta_inhibition_pkg.sv | 28 ++
 rtl/kwta_inhibition_if.sv | 48 ++++
 rtl/kwta_inhibition_priority.sv | 33 +++
 rtl/kwta_inhibition.sv | 137 +++++++++++++
 tb/tb_kwta_inhibition.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/kwta_inhibition_pkg.sv
// Shared helpers and types for the k-winner-take-all inhibition block.
// Default column size and winner count come from `NEURONS_PER_COLUMN / `NUM_WINNERS.
`ifndef NEURONS_PER_COLUMN
`define NEURONS_PER_COLUMN 8
`endif
`ifndef NUM_WINNERS
`define NUM_WINNERS 2
`endif

package tnn_wta_pkg;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int count_width(input int k);
        return $clog2(k + 1);
    endfunction

    localparam int DEF_NEURONS = `NEURONS_PER_COLUMN;
    localparam int DEF_WINNERS = `NUM_WINNERS;
    localparam int DEF_IDW     = id_width(DEF_NEURONS);

    typedef logic [DEF_IDW-1:0] wta_id_t;
    // Slot s lives at bits [s*IDW +: IDW] when viewed as a flat vector.
    typedef wta_id_t [DEF_WINNERS-1:0] wta_slots_t;

endpackage

// File: rtl/kwta_inhibition_if.sv
// Column-side bundle of the k-WTA block: spike lines, winner record and period snapshot.
// winner_ts exists only when KWTA_TIMESTAMP_EN is defined.
`ifndef NEURONS_PER_COLUMN
`define NEURONS_PER_COLUMN 8
`endif
`ifndef NUM_WINNERS
`define NUM_WINNERS 2
`endif

interface kwta_inhibition_if import tnn_wta_pkg::*; #(
    parameter int NEURONS     = `NEURONS_PER_COLUMN,
    parameter int NUM_WINNERS = `NUM_WINNERS,
    parameter int TS_WIDTH    = 4
) ();
    localparam int IDW = id_width(NEURONS);
    localparam int CW  = count_width(NUM_WINNERS);

    logic                        clear;
    logic [NEURONS-1:0]          in_spikes;
    logic [NEURONS-1:0]          out_spikes;
    logic [NUM_WINNERS*IDW-1:0]  winner_ids;
    logic [CW-1:0]               winner_count;
    logic                        no_winner;
    logic                        period_done;
    logic [NUM_WINNERS*IDW-1:0]  done_ids;
    logic [CW-1:0]               done_count;
`ifdef KWTA_TIMESTAMP_EN
    logic [NUM_WINNERS*TS_WIDTH-1:0] winner_ts;
`endif

    modport slave (
        input  clear, in_spikes,
        output out_spikes, winner_ids, winner_count, no_winner,
               period_done, done_ids, done_count
`ifdef KWTA_TIMESTAMP_EN
        , output winner_ts
`endif
    );

    modport master (
        output clear, in_spikes,
        input  out_spikes, winner_ids, winner_count, no_winner,
               period_done, done_ids, done_count
`ifdef KWTA_TIMESTAMP_EN
        , input winner_ts
`endif
    );
endinterface

// File: rtl/kwta_inhibition_priority.sv
// Combinational priority picker: passes up to 'remaining' lowest-index requests
// and lists their indices in ascending order.
module k_priority_select import tnn_wta_pkg::*; #(
    parameter int NEURONS     = 8,
    parameter int NUM_WINNERS = 2,
    localparam int IDW = id_width(NEURONS),
    localparam int CW  = count_width(NUM_WINNERS)
) (
    input  logic [NEURONS-1:0]                 req,
    input  logic [CW-1:0]                      remaining,
    output logic [NEURONS-1:0]                 sel,
    output logic [NUM_WINNERS-1:0][IDW-1:0]    ids,
    output logic [CW-1:0]                      n_sel
);

    always_comb begin
        sel   = '0;
        ids   = '0;
        n_sel = '0;
        for (int i = 0; i < NEURONS; i++) begin
            if (req[i] && (n_sel < remaining)) begin
                sel[i] = 1'b1;
                for (int s = 0; s < NUM_WINNERS; s++) begin
                    if (n_sel == CW'(s)) begin
                        ids[s] = IDW'(i);
                    end
                end
                n_sel = n_sel + CW'(1);
            end
        end
    end

endmodule

// File: rtl/kwta_inhibition.sv
// k-winner-take-all lateral inhibition for one excitatory column (spikes active low).
// Optional per-slot selection timestamps under KWTA_TIMESTAMP_EN.
`ifndef NEURONS_PER_COLUMN
`define NEURONS_PER_COLUMN 8
`endif
`ifndef NUM_WINNERS
`define NUM_WINNERS 2
`endif

module kwta_inhibition import tnn_wta_pkg::*; #(
    parameter int NEURONS     = `NEURONS_PER_COLUMN,
    parameter int NUM_WINNERS = `NUM_WINNERS,
    parameter int TS_WIDTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    kwta_inhibition_if.slave bus
);
    localparam int IDW = id_width(NEURONS);
    localparam int CW  = count_width(NUM_WINNERS);

    logic [NEURONS-1:0] seen_reg, win_reg, seen_eff, win_eff;
    logic [NEURONS-1:0] seen_next, win_next, arrivals, sel;
    wta_slots_t         slot_reg, slot_eff, slot_next, sel_ids, done_ids_reg;
    logic [CW-1:0]      count_reg, count_eff, count_next, remaining, n_sel;
    logic [CW-1:0]      done_count_reg;
    logic               period_done_reg;

    // The clear cycle already belongs to the new period, so its spikes see empty state.
    assign seen_eff  = bus.clear ? '0 : seen_reg;
    assign win_eff   = bus.clear ? '0 : win_reg;
    assign slot_eff  = bus.clear ? '0 : slot_reg;
    assign count_eff = bus.clear ? '0 : count_reg;

    assign arrivals  = ~bus.in_spikes & ~seen_eff;
    assign remaining = CW'(NUM_WINNERS) - count_eff;

    k_priority_select #(
        .NEURONS     (NEURONS),
        .NUM_WINNERS (NUM_WINNERS)
    ) u_select (
        .req       (arrivals),
        .remaining (remaining),
        .sel       (sel),
        .ids       (sel_ids),
        .n_sel     (n_sel)
    );

    assign bus.out_spikes = bus.in_spikes | ~(win_eff | sel);

    assign seen_next  = seen_eff | ~bus.in_spikes;
    assign win_next   = win_eff | sel;
    assign count_next = count_eff + n_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WINNERS; gi++) begin : g_slot
            logic [IDW-1:0] pick;
            // New winners fill slots count_eff, count_eff+1, ... in ascending index order.
            always_comb begin
                pick = slot_eff[gi];
                for (int j = 0; j < NUM_WINNERS; j++) begin
                    if ((CW'(j) < n_sel) && ((count_eff + CW'(j)) == CW'(gi))) begin
                        pick = sel_ids[j];
                    end
                end
            end
            assign slot_next[gi] = pick;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_reg        <= '0;
            win_reg         <= '0;
            slot_reg        <= '0;
            count_reg       <= '0;
            period_done_reg <= 1'b0;
            done_ids_reg    <= '0;
            done_count_reg  <= '0;
        end else begin
            seen_reg        <= seen_next;
            win_reg         <= win_next;
            slot_reg        <= slot_next;
            count_reg       <= count_next;
            period_done_reg <= bus.clear;
            if (bus.clear) begin
                done_ids_reg   <= slot_reg;
                done_count_reg <= count_reg;
            end
        end
    end

    assign bus.winner_ids   = slot_reg;
    assign bus.winner_count = count_reg;
    assign bus.no_winner    = (count_reg == '0);
    assign bus.period_done  = period_done_reg;
    assign bus.done_ids     = done_ids_reg;
    assign bus.done_count   = done_count_reg;

`ifdef KWTA_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]                     ts_reg, ts_eff, ts_next;
    logic [NUM_WINNERS-1:0][TS_WIDTH-1:0]    ts_slot_reg, ts_slot_eff, ts_slot_next;

    assign ts_eff      = bus.clear ? '0 : ts_reg;
    assign ts_next     = (&ts_eff) ? ts_eff : ts_eff + TS_WIDTH'(1);
    assign ts_slot_eff = bus.clear ? '0 : ts_slot_reg;

    generate
        for (gi = 0; gi < NUM_WINNERS; gi++) begin : g_ts
            logic hit;
            always_comb begin
                hit = 1'b0;
                for (int j = 0; j < NUM_WINNERS; j++) begin
                    if ((CW'(j) < n_sel) && ((count_eff + CW'(j)) == CW'(gi))) begin
                        hit = 1'b1;
                    end
                end
            end
            assign ts_slot_next[gi] = hit ? ts_eff : ts_slot_eff[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg      <= '0;
            ts_slot_reg <= '0;
        end else begin
            ts_reg      <= ts_next;
            ts_slot_reg <= ts_slot_next;
        end
    end

    assign bus.winner_ts = ts_slot_reg;
`endif

endmodule

// File: tb/tb_kwta_inhibition.sv
// Directed scoreboard bench for kwta_inhibition with NEURONS=8, NUM_WINNERS=2.
// Covers KWTA_TIMESTAMP_EN builds as well.
module tb_kwta_inhibition;
    localparam int N  = 8;
    localparam int K  = 2;
    localparam int TW = 4;

    localparam int K_OUT   = 0;
    localparam int K_IDS   = 1;
    localparam int K_CNT   = 2;
    localparam int K_NOW   = 3;
    localparam int K_PD    = 4;
    localparam int K_DIDS  = 5;
    localparam int K_DCNT  = 6;
    localparam int K_TS    = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    kwta_inhibition_if #(.NEURONS(N), .NUM_WINNERS(K), .TS_WIDTH(TW)) bus ();

    kwta_inhibition #(.NEURONS(N), .NUM_WINNERS(K), .TS_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_OUT:  return 32'(bus.out_spikes);
            K_IDS:  return 32'(bus.winner_ids);
            K_CNT:  return 32'(bus.winner_count);
            K_NOW:  return 32'(bus.no_winner);
            K_PD:   return 32'(bus.period_done);
            K_DIDS: return 32'(bus.done_ids);
            K_DCNT: return 32'(bus.done_count);
`ifdef KWTA_TIMESTAMP_EN
            K_TS:   return 32'(bus.winner_ts);
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.kind);
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
            $display("check %s observed=%0h expected=%0h", e.tag, o, e.val);
        end
    endtask

    // Drive one cycle of stimulus and check the zero-latency inhibited outputs.
    task automatic drive(input logic c, input logic [N-1:0] s, input logic [N-1:0] exp_out, input string tag);
        bus.clear     = c;
        bus.in_spikes = s;
        #2;
        push({tag, ".out"}, K_OUT, 32'(exp_out));
        check_all();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clear     = 1'b0;
        bus.in_spikes = '1;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        push("rst.ids", K_IDS, 0);
        push("rst.cnt", K_CNT, 0);
        push("rst.now", K_NOW, 1);
        push("rst.pd", K_PD, 0);
        push("rst.dids", K_DIDS, 0);
        push("rst.dcnt", K_DCNT, 0);
        push("rst.out", K_OUT, 32'hFF);
`ifdef KWTA_TIMESTAMP_EN
        push("rst.ts", K_TS, 0);
`endif
        check_all();
        rst_n = 1'b1;

        // Single winner two cycles after clear
        drive(1'b0 | 1'b1, 8'hFF, 8'hFF, "a.clr");
        push("a.clr.pd", K_PD, 1);
        push("a.clr.dcnt", K_DCNT, 0);
        push("a.clr.cnt", K_CNT, 0);
        tick();
        drive(1'b0, 8'hFF, 8'hFF, "a.t1");
        push("a.t1.pd", K_PD, 0);
        tick();
        drive(1'b0, 8'hF7, 8'hF7, "a.t2");
        push("a.t2.ids", K_IDS, 3);
        push("a.t2.cnt", K_CNT, 1);
        push("a.t2.now", K_NOW, 0);
`ifdef KWTA_TIMESTAMP_EN
        push("a.t2.ts", K_TS, 2);
`endif
        tick();
        drive(1'b0, 8'hF7, 8'hF7, "a.hold");
        push("a.hold.cnt", K_CNT, 1);
        tick();

        // Three simultaneous arrivals, capacity two
        drive(1'b1, 8'hFF, 8'hFF, "b.clr");
        push("b.clr.pd", K_PD, 1);
        push("b.clr.dids", K_DIDS, 3);
        push("b.clr.dcnt", K_DCNT, 1);
        push("b.clr.cnt", K_CNT, 0);
        push("b.clr.ids", K_IDS, 0);
        push("b.clr.now", K_NOW, 1);
        tick();
        drive(1'b0, 8'h5B, 8'hDB, "b.tri");
        push("b.tri.ids", K_IDS, 32'(2 | (5 << 3)));
        push("b.tri.cnt", K_CNT, 2);
`ifdef KWTA_TIMESTAMP_EN
        push("b.tri.ts", K_TS, 32'h11);
`endif
        tick();
        drive(1'b0, 8'h5A, 8'hDB, "b.sat");
        push("b.sat.cnt", K_CNT, 2);
        push("b.sat.ids", K_IDS, 32'(2 | (5 << 3)));
        tick();
        drive(1'b0, 8'hFF, 8'hFF, "b.rel");
        push("b.rel.cnt", K_CNT, 2);
        tick();

        // Back-to-back clears, second period empty
        drive(1'b1, 8'hFF, 8'hFF, "c.clr1");
        push("c.clr1.pd", K_PD, 1);
        push("c.clr1.dids", K_DIDS, 32'(2 | (5 << 3)));
        push("c.clr1.dcnt", K_DCNT, 2);
        tick();
        drive(1'b1, 8'hFF, 8'hFF, "c.clr2");
        push("c.clr2.pd", K_PD, 1);
        push("c.clr2.dids", K_DIDS, 0);
        push("c.clr2.dcnt", K_DCNT, 0);
        tick();
        drive(1'b0, 8'hFF, 8'hFF, "c.after");
        push("c.after.pd", K_PD, 0);
        tick();

        // Spike during the clear cycle belongs to the new period
        drive(1'b0, 8'hFD, 8'hFD, "d.pre");
        push("d.pre.ids", K_IDS, 1);
        push("d.pre.cnt", K_CNT, 1);
        tick();
        drive(1'b1, 8'hEF, 8'hEF, "d.clr");
        push("d.clr.pd", K_PD, 1);
        push("d.clr.dids", K_DIDS, 1);
        push("d.clr.dcnt", K_DCNT, 1);
        push("d.clr.ids", K_IDS, 4);
        push("d.clr.cnt", K_CNT, 1);
`ifdef KWTA_TIMESTAMP_EN
        push("d.clr.ts", K_TS, 0);
`endif
        tick();

        // Asynchronous reset mid-period with one winner recorded
        drive(1'b0, 8'hFF, 8'hFF, "e.idle");
        rst_n = 1'b0;
        #2;
        push("e.rst.ids", K_IDS, 0);
        push("e.rst.cnt", K_CNT, 0);
        push("e.rst.now", K_NOW, 1);
        push("e.rst.pd", K_PD, 0);
        push("e.rst.dids", K_DIDS, 0);
        push("e.rst.dcnt", K_DCNT, 0);
`ifdef KWTA_TIMESTAMP_EN
        push("e.rst.ts", K_TS, 0);
`endif
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b0, 8'hBF, 8'hBF, "e.l6");
        push("e.l6.ids", K_IDS, 6);
        push("e.l6.cnt", K_CNT, 1);
        push("e.l6.now", K_NOW, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
